// File: rtl/pulse_gen_if.sv
// pulse_gen_if: request/status bundle for pulse_gen.
// The master launches a pulse train with start plus length/count fields and
// observes the generated waveform and its status flags.
interface pulse_gen_if #(
  parameter int unsigned CW = 8
);
  logic          start;
  logic [CW-1:0] high_len;
  logic [CW-1:0] low_len;
  logic [CW-1:0] pulse_cnt;
  logic          data;
  logic          busy;
  logic          done;

  modport master (
    output start, high_len, low_len, pulse_cnt,
    input  data, busy, done
  );

  modport slave (
    input  start, high_len, low_len, pulse_cnt,
    output data, busy, done
  );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator.
// After an accepted start, emits pulse_cnt periods of max(high_len,1) cycles
// high followed by max(low_len,1) cycles low, then pulses done for one cycle.
// Optional feature: define PULSE_GEN_ABORT_EN to add the abort input, which
// terminates a running train (with a done pulse) on the next clock edge.
module pulse_gen #(
  parameter int unsigned CW = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef PULSE_GEN_ABORT_EN
  input  logic abort,
`endif
  pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        r_state,    w_state_nxt;
  logic [CW-1:0] r_high_len, w_high_len_nxt;
  logic [CW-1:0] r_low_len,  w_low_len_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic [CW-1:0] r_phase,    w_phase_nxt;
  logic          r_data,     w_data_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_done,     w_done_nxt;
  logic          w_abort;

`ifdef PULSE_GEN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // A zero length is treated as one cycle.
  function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] len);
    return (len == '0) ? ONE : len;
  endfunction

  // Next-state and output decode; phase counter counts down to 1 so a
  // full-scale length never needs a CW+1-bit value.
  always_comb begin
    w_state_nxt    = r_state;
    w_high_len_nxt = r_high_len;
    w_low_len_nxt  = r_low_len;
    w_cnt_nxt      = r_cnt;
    w_phase_nxt    = r_phase;
    w_data_nxt     = r_data;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        // Start in the done cycle is refused so a train is never back-to-back.
        if (bus.start && !r_done && (bus.pulse_cnt != '0)) begin
          w_state_nxt    = HIGH;
          w_high_len_nxt = eff_len(bus.high_len);
          w_low_len_nxt  = eff_len(bus.low_len);
          w_cnt_nxt      = bus.pulse_cnt;
          w_phase_nxt    = eff_len(bus.high_len);
          w_data_nxt     = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end
      HIGH: begin
        if (r_phase == ONE) begin
          w_state_nxt = LOW;
          w_phase_nxt = r_low_len;
          w_data_nxt  = 1'b0;
        end else begin
          w_phase_nxt = r_phase - ONE;
        end
      end
      LOW: begin
        if (r_phase == ONE) begin
          if (r_cnt == ONE) begin
            w_state_nxt    = IDLE;
            w_high_len_nxt = '0;
            w_low_len_nxt  = '0;
            w_cnt_nxt      = '0;
            w_phase_nxt    = '0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
          end else begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = r_cnt - ONE;
            w_phase_nxt = r_high_len;
            w_data_nxt  = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase - ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_data_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    if (w_abort && (r_state != IDLE)) begin
      w_state_nxt    = IDLE;
      w_high_len_nxt = '0;
      w_low_len_nxt  = '0;
      w_cnt_nxt      = '0;
      w_phase_nxt    = '0;
      w_data_nxt     = 1'b0;
      w_busy_nxt     = 1'b0;
      w_done_nxt     = 1'b1;
    end
  end

  // State, counters and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_high_len <= '0;
      r_low_len  <= '0;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_data     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_high_len <= w_high_len_nxt;
      r_low_len  <= w_low_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_data     <= w_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.data = r_data;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed self-checking bench for pulse_gen (CW=8).
// A per-cycle vector table covers the basic trains; hand-written sequences
// cover ignored starts, mid-train reset, full-scale length and abort.
module tb_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef PULSE_GEN_ABORT_EN
  logic abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pulse_gen_if #(.CW(8)) bus ();

  pulse_gen #(.CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef PULSE_GEN_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] h;
    logic [7:0] l;
    logic [7:0] n;
    logic       d;
    logic       b;
    logic       dn;
  } vec_t;

  vec_t tbl [23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Launch a train and check every cycle against a period model. At cycle
  // 'poke' a second start with different fields is driven; it must not matter.
  task automatic run_train(input string nm, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] n, input int poke);
    int he, le, per, tot, rises, pos;
    logic prev;
    bus.start = 1'b1; bus.high_len = h; bus.low_len = l; bus.pulse_cnt = n;
    tick();
    bus.start = 1'b0;
    he = (h == 0) ? 1 : int'(h);
    le = (l == 0) ? 1 : int'(l);
    per = he + le;
    tot = int'(n) * per;
    rises = 0;
    prev = 1'b0;
    for (int k = 1; k <= tot; k++) begin
      pos = (k - 1) % per;
      chk($sformatf("%s_data_c%0d", nm, k), bus.data, (pos < he) ? 1 : 0);
      chk($sformatf("%s_busy_c%0d", nm, k), bus.busy, 1);
      chk($sformatf("%s_done_c%0d", nm, k), bus.done, 0);
      if (bus.data && !prev) rises++;
      prev = bus.data;
      if (k == poke) begin
        bus.start = 1'b1; bus.high_len = 8'd1; bus.low_len = 8'd7; bus.pulse_cnt = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    chk({nm, "_end_done"}, bus.done, 1);
    chk({nm, "_end_busy"}, bus.busy, 0);
    chk({nm, "_end_data"}, bus.data, 0);
    chk({nm, "_rises"}, rises, int'(n));
    tick();
    chk({nm, "_post_done"}, bus.done, 0);
    chk({nm, "_post_busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.high_len = '0; bus.low_len = '0; bus.pulse_cnt = '0;

    // rst start  h  l  n   data busy done   (outputs after the edge)
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'd3, 8'd2, 8'd2, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0}; // start in done cycle
    tbl[13] = '{1'b0, 1'b1, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0}; // start after done
    tbl[14] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; bus.start = tbl[i].start;
      bus.high_len = tbl[i].h; bus.low_len = tbl[i].l; bus.pulse_cnt = tbl[i].n;
      tick();
      chk($sformatf("tbl%0d_data", i), bus.data, tbl[i].d);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].b);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].dn);
    end
    bus.start = 1'b0;

    // Start with zero pulse count is ignored.
    bus.start = 1'b1; bus.high_len = 8'd5; bus.low_len = 8'd1; bus.pulse_cnt = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("cnt0_busy", bus.busy, 0);
    chk("cnt0_data", bus.data, 0);
    tick();
    chk("cnt0_busy2", bus.busy, 0);

    // Start plus changed fields in cycle 5 of a running train are ignored.
    run_train("busy_ign", 8'd5, 8'd1, 8'd1, 5);

    // Reset in cycle 4 of a 2/2/3 train.
    bus.start = 1'b1; bus.high_len = 8'd2; bus.low_len = 8'd2; bus.pulse_cnt = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("rst_pre_data_c%0d", k), bus.data, (k <= 2) ? 1 : 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_data", bus.data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_nodone%0d", k), bus.done, 0);
      chk($sformatf("rst_idle%0d", k), bus.busy, 0);
    end
    run_train("after_rst", 8'd2, 8'd2, 8'd3, 0);

    // Start together with reset is ignored.
    rst = 1'b1; bus.start = 1'b1; bus.pulse_cnt = 8'd2;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    tick();
    chk("rst_start_busy2", bus.busy, 0);
    chk("rst_start_data2", bus.data, 0);

    // Zero lengths toggle every cycle; full-scale high length.
    run_train("zero_len", 8'd0, 8'd0, 8'd4, 0);
    run_train("max_len", 8'd255, 8'd1, 8'd1, 0);

`ifdef PULSE_GEN_ABORT_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", bus.busy, 0);
    chk("abort_idle_done", bus.done, 0);
    bus.start = 1'b1; bus.high_len = 8'd6; bus.low_len = 8'd1; bus.pulse_cnt = 8'd1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_pre_data", bus.data, 1);
    abort = 1'b1; bus.start = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_data", bus.data, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 1);
    tick();
    bus.start = 1'b0;
    chk("abort_post_done", bus.done, 0);
    chk("abort_post_busy", bus.busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter: CW, 8, width of length and count fields.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle request to launch a pulse train.
REQ-005 SHALL have port: high_len  input  CW  high-phase length in clk cycles.
REQ-006 SHALL have port: low_len  input  CW  low-phase length in clk cycles.
REQ-007 SHALL have port: pulse_cnt  input  CW  number of pulses in the train.
REQ-008 SHALL have port: data  output  1  registered generated waveform.
REQ-009 SHALL have port: busy  output  1  high while a train is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at train completion.

Function
REQ-011 SHALL implement FSM states IDLE, HIGH, LOW; reset state IDLE.
REQ-012 SHALL accept start only in IDLE with pulse_cnt != 0; start with pulse_cnt == 0, or start while busy, SHALL be ignored with no output change.
REQ-013 SHALL latch high_len, low_len and pulse_cnt on the accepting cycle; later input changes SHALL NOT affect the running train.
REQ-014 SHALL treat a latched length of 0 as 1.
REQ-015 SHALL enter HIGH on the cycle after acceptance; data and busy SHALL be 1 from that cycle.
REQ-016 HIGH SHALL last exactly max(high_len,1) cycles with data=1, then go to LOW.
REQ-017 LOW SHALL last exactly max(low_len,1) cycles with data=0. At its end SHALL go to HIGH if pulses remain, else to IDLE.
REQ-018 SHALL keep the phase counter and the pulse counter CW bits wide, with no wrap-around. Length 2^CW-1 SHALL produce exactly 2^CW-1 cycles.
REQ-019 On return to IDLE, busy SHALL fall and done SHALL be 1 for exactly that one cycle.
REQ-020 Start SHALL NOT be accepted in the done cycle. Start in the cycle after done SHALL be accepted.
REQ-021 data SHALL be 0 in IDLE. It SHALL come straight from a flop, with no combinational path from any input.
REQ-022 Total train length SHALL be pulse_cnt*(H+L) cycles from the first HIGH cycle to the last LOW cycle inclusive, where H and L are the effective lengths.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, with data=0, busy=0, done=0 and all counters 0, including mid-train.
REQ-024 start asserted in the same cycle as rst SHALL be ignored.
REQ-025 No done pulse SHALL be emitted for a train aborted by reset.

Configuration
REQ-026 Macro PULSE_GEN_ABORT_EN SHALL, when defined, add port: abort  input  1  request to terminate the running train.
REQ-027 With PULSE_GEN_ABORT_EN defined, abort=1 while busy SHALL force IDLE next cycle with data=0 and busy=0. done SHALL pulse for that one cycle. Abort SHALL take priority over start. Abort in IDLE SHALL have no effect.
REQ-028 Without PULSE_GEN_ABORT_EN, the abort port SHALL NOT exist and a train SHALL end only by completion or rst.

Verification
REQ-029 Reset then start, high_len=3, low_len=2, pulse_cnt=2 -> data pattern 1,1,1,0,0,1,1,1,0,0 from cycle after start; busy high for 10 cycles; done at cycle 11.
REQ-030 Start, high_len=0, low_len=0, pulse_cnt=4 -> data toggles every cycle 1,0,1,0,1,0,1,0; exactly 4 rising and 4 falling edges counted; done one cycle.
REQ-031 Start with pulse_cnt=0, then start at cycle 5 of a running train (high_len=5) -> busy stays 0 for the first; second start ignored, running train unchanged, inputs changed mid-train have no effect.
REQ-032 rst asserted in cycle 4 of a train (high_len=2, low_len=2, pulse_cnt=3) -> next cycle data=0, busy=0, done never pulses; new start then produces full 12-cycle train.
REQ-033 CW=8, high_len=255, low_len=1, pulse_cnt=1 -> data high exactly 255 cycles, low 1 cycle, done once.
REQ-034 With PULSE_GEN_ABORT_EN: abort in cycle 3 of HIGH (high_len=6) together with start -> next cycle data=0, busy=0, done=1 for one cycle; start ignored.
